// File: rtl/spi_sram_responder.sv
// SPI (mode 0) responder that exposes a byte-addressed SRAM through READ (0x03)
// and WRITE (0x02) commands with 24-bit addresses and sequential streaming.
module spi_sram_responder #(
    parameter int unsigned ADDR_BITS = 16
) (
    input  logic                 clk,
    input  logic                 rstn,
    input  logic                 spi_select,
    input  logic                 spi_clk,
    input  logic                 spi_mosi,
    output logic                 spi_miso,
    output logic [ADDR_BITS-1:0] mem_addr,
    output logic [7:0]           mem_wdata,
    output logic                 mem_we,
    output logic                 mem_re,
    input  logic [7:0]           mem_rdata,
    output logic                 busy
);

    typedef enum logic [2:0] {IDLE, CMD, ADDR, READ, WRITE, IGNORE} state_t;

    logic [1:0]           sel_s_q, sck_s_q, mosi_s_q;
    logic                 sck_prev_q, sel_prev_q;
    logic [1:0]           flush_q;
    state_t               state_q, state_d;
    logic [4:0]           bitcnt_q, bitcnt_d;
    logic [7:0]           shift_q, shift_d;
    logic [7:0]           tx_q, tx_d;
    logic                 is_wr_q, is_wr_d;
    logic [ADDR_BITS-1:0] addr_q, addr_d;
    logic [7:0]           wdata_q, wdata_d;
    logic                 we_q, we_d;
    logic                 re_q, re_d;
    logic                 ld_q, ld_d;
    logic                 miso_q, miso_d;

    logic       sel, sck, mosi, sck_rise, sck_fall, sel_fall;
    logic [7:0] shift_in;

    assign sel      = sel_s_q[1];
    assign sck      = sck_s_q[1];
    assign mosi     = mosi_s_q[1];
    assign sck_rise = sck & ~sck_prev_q;
    assign sck_fall = ~sck & sck_prev_q;
    assign sel_fall = sel_prev_q & ~sel;
    assign shift_in = {shift_q[6:0], mosi};

    assign spi_miso  = miso_q;
    assign mem_addr  = addr_q;
    assign mem_wdata = wdata_q;
    assign mem_we    = we_q;
    assign mem_re    = re_q;
    assign busy      = ~sel;

    always_comb begin
        state_d  = state_q;
        bitcnt_d = bitcnt_q;
        shift_d  = shift_q;
        tx_d     = tx_q;
        is_wr_d  = is_wr_q;
        addr_d   = addr_q;
        wdata_d  = wdata_q;
        we_d     = 1'b0;
        re_d     = 1'b0;
        ld_d     = re_q;
        miso_d   = 1'b1;
        // Read data arrives the cycle after the strobe; post-write address bump.
        if (ld_q) tx_d = mem_rdata;
        if (we_q) addr_d = addr_q + 1'b1;

        case (state_q)
            IDLE: if (sel_fall) begin
                state_d  = CMD;
                bitcnt_d = '0;
            end
            CMD: if (sck_rise) begin
                shift_d  = shift_in;
                bitcnt_d = bitcnt_q + 5'd1;
                if (bitcnt_q == 5'd7) begin
                    bitcnt_d = '0;
                    case (shift_in)
                        8'h03:   begin state_d = ADDR; is_wr_d = 1'b0; end
                        8'h02:   begin state_d = ADDR; is_wr_d = 1'b1; end
                        default: state_d = IGNORE;
                    endcase
                end
            end
            ADDR: if (sck_rise) begin
                // Shifting straight into the address keeps only the low ADDR_BITS.
                addr_d   = {addr_q[ADDR_BITS-2:0], mosi};
                bitcnt_d = bitcnt_q + 5'd1;
                if (bitcnt_q == 5'd23) begin
                    bitcnt_d = '0;
                    if (is_wr_q) state_d = WRITE;
                    else begin
                        state_d = READ;
                        re_d    = 1'b1;
                    end
                end
            end
            READ: begin
                miso_d = miso_q;
                if (sck_fall) begin
                    miso_d = tx_q[7];
                    tx_d   = {tx_q[6:0], 1'b1};
                end
                if (sck_rise) begin
                    bitcnt_d = bitcnt_q + 5'd1;
                    if (bitcnt_q == 5'd7) begin
                        bitcnt_d = '0;
                        addr_d   = addr_q + 1'b1;
                        re_d     = 1'b1;
                    end
                end
            end
            WRITE: if (sck_rise) begin
                shift_d  = shift_in;
                bitcnt_d = bitcnt_q + 5'd1;
                if (bitcnt_q == 5'd7) begin
                    bitcnt_d = '0;
                    we_d     = 1'b1;
                    wdata_d  = shift_in;
                end
            end
            IGNORE: ;
            default: state_d = IDLE;
        endcase

        if (state_q != IDLE && sel) begin
            state_d  = IDLE;
            bitcnt_d = '0;
            we_d     = 1'b0;
            re_d     = 1'b0;
            miso_d   = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (!rstn) begin
            sel_s_q    <= 2'b11;
            sck_s_q    <= 2'b00;
            mosi_s_q   <= 2'b00;
            sck_prev_q <= 1'b0;
            sel_prev_q <= 1'b0;
            flush_q    <= 2'd0;
            state_q    <= IDLE;
            bitcnt_q   <= '0;
            shift_q    <= '0;
            tx_q       <= '0;
            is_wr_q    <= 1'b0;
            addr_q     <= '0;
            wdata_q    <= '0;
            we_q       <= 1'b0;
            re_q       <= 1'b0;
            ld_q       <= 1'b0;
            miso_q     <= 1'b1;
        end else begin
            sel_s_q    <= {sel_s_q[0], spi_select};
            sck_s_q    <= {sck_s_q[0], spi_clk};
            mosi_s_q   <= {mosi_s_q[0], spi_mosi};
            sck_prev_q <= sck;
            // Until the synchroniser holds real samples, a select already low
            // must not look like a fresh falling edge.
            if (flush_q != 2'd2) flush_q <= flush_q + 2'd1;
            sel_prev_q <= (flush_q == 2'd2) ? sel : 1'b0;
            state_q    <= state_d;
            bitcnt_q   <= bitcnt_d;
            shift_q    <= shift_d;
            tx_q       <= tx_d;
            is_wr_q    <= is_wr_d;
            addr_q     <= addr_d;
            wdata_q    <= wdata_d;
            we_q       <= we_d;
            re_q       <= re_d;
            ld_q       <= ld_d;
            miso_q     <= miso_d;
        end
    end

endmodule

// File: tb/tb_spi_sram_responder.sv
// Bench for spi_sram_responder: SPI initiator tasks, SRAM model and a write/read scoreboard.
module tb_spi_sram_responder;
    localparam int AB = 16;

    logic          clk = 1'b0, rstn = 1'b0;
    logic          spi_select = 1'b1, spi_clk = 1'b0, spi_mosi = 1'b0;
    logic          spi_miso, mem_we, mem_re, busy;
    logic [AB-1:0] mem_addr;
    logic [7:0]    mem_wdata;
    logic [7:0]    mem_rdata = 8'h00;

    int vecs = 0, errs = 0, n_we = 0, n_re = 0, half = 4;
    logic [7:0]  mem [0:65535];
    logic [23:0] exp_wq[$];
    logic [7:0]  exp_rq[$];
    logic [23:0] mon_e;

    spi_sram_responder #(.ADDR_BITS(AB)) dut (
        .clk(clk), .rstn(rstn), .spi_select(spi_select), .spi_clk(spi_clk),
        .spi_mosi(spi_mosi), .spi_miso(spi_miso), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .mem_we(mem_we), .mem_re(mem_re),
        .mem_rdata(mem_rdata), .busy(busy));

    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (mem_we) mem[mem_addr] <= mem_wdata;
        if (mem_re) mem_rdata <= mem[mem_addr];
    end

    // Write scoreboard: every strobe must match the next expected (addr,data).
    always @(negedge clk) begin
        if (mem_we && mem_re) begin
            vecs++; errs++;
            $display("FAIL strobe_overlap we=%b re=%b required not both", mem_we, mem_re);
        end
        if (mem_re) n_re++;
        if (mem_we) begin
            n_we++; vecs++;
            if (exp_wq.size() == 0) begin
                errs++;
                $display("FAIL unexpected_write addr=%h data=%h required none", mem_addr, mem_wdata);
            end else begin
                mon_e = exp_wq.pop_front();
                if ({mem_addr, mem_wdata} !== mon_e) begin
                    errs++;
                    $display("FAIL write addr/data=%h/%h required %h/%h",
                             mem_addr, mem_wdata, mon_e[23:8], mon_e[7:0]);
                end
            end
        end
    end

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic spi_bit(input logic b, output logic m);
        spi_mosi = b;
        tick(half);
        m = spi_miso;
        spi_clk = 1'b1;
        tick(half);
        spi_clk = 1'b0;
    endtask

    task automatic spi_byte(input logic [7:0] o, output logic [7:0] r);
        logic b;
        for (int i = 7; i >= 0; i--) begin
            spi_bit(o[i], b);
            r[i] = b;
        end
    endtask

    task automatic sel_low();
        spi_select = 1'b0;
        tick(half + 4);
    endtask

    task automatic sel_high();
        tick(half);
        spi_select = 1'b1;
        tick(half + 8);
    endtask

    task automatic write_burst(input logic [15:0] a, input logic [7:0] d0, input logic [7:0] d1);
        logic [7:0] r;
        exp_wq.push_back({a, d0});
        exp_wq.push_back({a + 16'd1, d1});
        sel_low();
        spi_byte(8'h02, r); spi_byte(8'h00, r); spi_byte(a[15:8], r); spi_byte(a[7:0], r);
        spi_byte(d0, r); spi_byte(d1, r);
        sel_high();
        vecs++;
        if (exp_wq.size() !== 0) begin
            errs++;
            $display("FAIL writes_pending at %h: %0d left, required 0", a, exp_wq.size());
            exp_wq.delete();
        end
    endtask

    task automatic read_check(input logic [15:0] a, input logic [7:0] e0, input logic [7:0] e1);
        logic [7:0] r, e;
        exp_rq.push_back(e0);
        exp_rq.push_back(e1);
        sel_low();
        spi_byte(8'h03, r); spi_byte(8'h00, r); spi_byte(a[15:8], r); spi_byte(a[7:0], r);
        for (int k = 0; k < 2; k++) begin
            spi_byte(8'h00, r);
            e = exp_rq.pop_front();
            vecs++;
            if (r !== e) begin
                errs++;
                $display("FAIL read_byte%0d addr=%h got %h required %h (half=%0d)", k, a, r, e, half);
            end
        end
        sel_high();
        vecs++;
        if (spi_miso !== 1'b1) begin
            errs++;
            $display("FAIL miso_idle got %b required 1", spi_miso);
        end
    endtask

    task automatic test_reset();
        rstn = 1'b0; spi_select = 1'b1;
        tick(4);
        vecs++;
        if ({spi_miso, mem_we, mem_re, busy} !== 4'b1000) begin
            errs++;
            $display("FAIL reset_ctrl miso/we/re/busy=%b required 1000", {spi_miso, mem_we, mem_re, busy});
        end
        vecs++;
        if ({mem_addr, mem_wdata} !== 24'h0) begin
            errs++;
            $display("FAIL reset_data addr/wdata=%h required 000000", {mem_addr, mem_wdata});
        end
        rstn = 1'b1;
        tick(4);
    endtask

    // Select already low when reset releases must not start a transaction.
    task automatic test_select_held();
        logic [7:0] r;
        int pre;
        rstn = 1'b0; spi_select = 1'b0;
        tick(4);
        rstn = 1'b1;
        tick(6);
        vecs++;
        if (busy !== 1'b1) begin
            errs++;
            $display("FAIL held_busy got %b required 1", busy);
        end
        pre = n_we;
        spi_byte(8'h02, r); spi_byte(8'h00, r); spi_byte(8'h00, r); spi_byte(8'h40, r);
        spi_byte(8'h77, r);
        sel_high();
        vecs++;
        if (n_we !== pre) begin
            errs++;
            $display("FAIL held_no_write we_count=%0d required %0d", n_we, pre);
        end
    endtask

    task automatic test_write_read(input int h);
        half = h;
        write_burst(16'h1234, 8'hA5, 8'h5A);
        read_check(16'h1234, 8'hA5, 8'h5A);
    endtask

    task automatic test_wrap();
        half = 4;
        write_burst(16'hFFFF, 8'h11, 8'h22);
        read_check(16'hFFFF, 8'h11, 8'h22);
    endtask

    task automatic test_unknown();
        logic [7:0] r;
        int pw, pr;
        pw = n_we; pr = n_re;
        sel_low();
        spi_byte(8'h9F, r);
        vecs++;
        if (r !== 8'hFF) begin
            errs++;
            $display("FAIL unknown_cmd_miso got %h required ff", r);
        end
        for (int k = 0; k < 4; k++) begin
            spi_byte(8'h5C, r);
            vecs++;
            if (r !== 8'hFF) begin
                errs++;
                $display("FAIL unknown_miso byte%0d got %h required ff", k, r);
            end
        end
        sel_high();
        vecs++;
        if ({n_we, n_re} !== {pw, pr}) begin
            errs++;
            $display("FAIL unknown_strobes we=%0d re=%0d required %0d %0d", n_we, n_re, pw, pr);
        end
    endtask

    task automatic test_early_deselect();
        logic [7:0] r;
        logic b;
        int pw;
        pw = n_we;
        sel_low();
        spi_byte(8'h02, r); spi_byte(8'h00, r); spi_byte(8'h00, r); spi_byte(8'h10, r);
        for (int k = 0; k < 5; k++) spi_bit(k[0], b);
        tick(half);
        spi_select = 1'b1;
        tick(3);
        vecs++;
        if ({busy, spi_miso} !== 2'b01) begin
            errs++;
            $display("FAIL early_desel busy/miso=%b required 01", {busy, spi_miso});
        end
        tick(10);
        vecs++;
        if (n_we !== pw) begin
            errs++;
            $display("FAIL early_desel_write we_count=%0d required %0d", n_we, pw);
        end
        write_burst(16'h0010, 8'h77, 8'h88);
        read_check(16'h0010, 8'h77, 8'h88);
    endtask

    task automatic test_reset_mid_read();
        logic [7:0] r, e;
        logic b;
        int pr;
        write_burst(16'h0100, 8'hC3, 8'h3C);
        exp_rq.push_back(8'hC3);
        sel_low();
        spi_byte(8'h03, r); spi_byte(8'h00, r); spi_byte(8'h01, r); spi_byte(8'h00, r);
        spi_byte(8'h00, r);
        e = exp_rq.pop_front();
        vecs++;
        if (r !== e) begin
            errs++;
            $display("FAIL midrd_byte0 got %h required %h", r, e);
        end
        for (int k = 0; k < 4; k++) spi_bit(1'b0, b);
        rstn = 1'b0;
        tick(3);
        rstn = 1'b1;
        pr = n_re;
        for (int k = 0; k < 12; k++) spi_bit(1'b0, b);
        vecs++;
        if (spi_miso !== 1'b1) begin
            errs++;
            $display("FAIL midrd_miso got %b required 1", spi_miso);
        end
        vecs++;
        if (n_re !== pr) begin
            errs++;
            $display("FAIL midrd_no_re re_count=%0d required %0d", n_re, pr);
        end
        sel_high();
        read_check(16'h0100, 8'hC3, 8'h3C);
    endtask

    initial begin
        test_reset();
        test_select_held();
        test_write_read(4);
        test_write_read(20);
        test_wrap();
        test_unknown();
        test_early_deselect();
        test_reset_mid_read();
        $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
        $finish;
    end
endmodule

// File: doc/spi_sram_responder.md
SPI_SRAM_RESPONDER -- requirements
Module: spi_sram_responder

Interface
REQ-001 The block SHALL have parameter ADDR_BITS, default 16, meaning the width of the backing-memory byte address; addresses wrap modulo 2^ADDR_BITS.
REQ-002 The block SHALL have port clk, input, 1, the single system clock; all logic is on the rising edge.
REQ-003 The block SHALL have port rstn, input, 1: reset is synchronous and active-low.
REQ-004 The block SHALL have port spi_select, input, 1, the chip select from the SPI initiator, active-low and asynchronous to clk.
REQ-005 The block SHALL have port spi_clk, input, 1, the SPI clock in mode 0 (idle low), asynchronous to clk.
REQ-006 The block SHALL have port spi_mosi, input, 1, the initiator-to-responder serial data, sent MSB first.
REQ-007 The block SHALL have port spi_miso, output, 1, the responder-to-initiator serial data, registered.
REQ-008 The block SHALL have port mem_addr, output, ADDR_BITS, the backing-memory byte address, registered.
REQ-009 The block SHALL have port mem_wdata, output, 8, the write data byte, registered.
REQ-010 The block SHALL have port mem_we, output, 1, a one-cycle write strobe.
REQ-011 The block SHALL have port mem_re, output, 1, a one-cycle read strobe.
REQ-012 The block SHALL have port mem_rdata, input, 8, the read data, valid exactly 1 clk after mem_re.
REQ-013 The block SHALL have port busy, output, 1, high whenever the synchronised spi_select is low.

Function
REQ-014 spi_select, spi_clk and spi_mosi SHALL each pass through a 2-flop synchroniser before use; SCK edges SHALL be detected by comparing the synchronised value against its previous value.
REQ-015 Correct operation SHALL be required only when the SCK high and low phases are each at least 4 clk cycles long; behaviour at faster SCK is undefined.
REQ-016 The state machine SHALL have states IDLE, CMD, ADDR, READ, WRITE and IGNORE.
REQ-017 In IDLE, the synchronised spi_select falling SHALL cause a transition to CMD with the bit counter cleared.
REQ-018 MOSI SHALL be sampled on each detected SCK rising edge and shifted in MSB first.
REQ-019 CMD SHALL collect 8 bits; 0x03 SHALL lead to ADDR (read), 0x02 SHALL lead to ADDR (write), and any other value SHALL lead to IGNORE.
REQ-020 ADDR SHALL collect 24 bits; the low ADDR_BITS bits SHALL be the start address and the upper bits SHALL be ignored.
REQ-021 On the 24th address bit of a read, the block SHALL assert mem_re with mem_addr equal to the start address on the next clk, load the returned byte into the TX shift register, and enter READ.
REQ-022 READ: on each detected SCK falling edge, spi_miso SHALL output the next TX bit, MSB first, 1 clk after detection; the first falling edge after the final address bit SHALL present bit 7 of byte 0.
REQ-023 READ: on the 8th rising edge of each data byte, the block SHALL increment mem_addr with wrap, pulse mem_re, and reload the TX shift register before the next falling edge, giving continuous sequential streaming.
REQ-024 On the 24th address bit of a write, the block SHALL enter WRITE with mem_addr equal to the start address.
REQ-025 WRITE: after every 8 collected bits, the block SHALL pulse mem_we for 1 clk with mem_wdata equal to the byte, then increment mem_addr with wrap.
REQ-026 IGNORE SHALL discard all SCK activity until deselect.
REQ-027 spi_miso SHALL be 1 in every state other than READ.
REQ-028 The synchronised spi_select rising in any state SHALL return the block to IDLE on the next clk.
REQ-029 On deselect, the block SHALL discard a partial command, partial address or partial write byte, with no mem_we for the partial byte.
REQ-030 mem_we and mem_re SHALL never be asserted in the same cycle, and neither SHALL be asserted in IDLE or IGNORE.
REQ-031 Address wrap: incrementing from 2^ADDR_BITS-1 SHALL yield 0.

Reset
REQ-032 While rstn is low at a clk edge, the block SHALL be in IDLE, with spi_miso=1, mem_we=0, mem_re=0, busy=0, mem_addr=0, mem_wdata=0, counters=0, and synchroniser flops reset to select=1, sck=0 and mosi=0.
REQ-033 Reset asserted mid-transaction SHALL abort the transaction with no further memory strobes.
REQ-034 After reset, the block SHALL wait for the synchronised spi_select to go high before accepting a new falling edge.

Verification
REQ-035 Write then read back: select low, send 02 00 12 34 A5 5A, then deselect -> mem_we pulses twice, writing 0x1234=A5 then 0x1235=5A; a following read 03 00 12 34 with 16 SCKs -> spi_miso bytes A5 5A sampled on SCK rising edges.
REQ-036 Wrap: write 02 00 FF FF 11 22 with ADDR_BITS=16 -> writes 0xFFFF=11 then 0x0000=22.
REQ-037 Unknown command: send 9F followed by 32 SCKs -> no mem_we/mem_re, and spi_miso stays 1 throughout.
REQ-038 Early deselect: 02 00 00 10 followed by 5 data bits, then select high -> no mem_we; state returns to IDLE and busy=0 within 3 clk.
REQ-039 Reset mid-read: assert rstn=0 during byte 1 of a streaming read -> spi_miso=1 and no mem_re after reset; then select high/low and command 03 works normally.
REQ-040 Minimum SCK: run the write/read-back scenario with SCK period = 8 clk and with SCK period = 40 clk -> identical data in both cases.
